// File: rtl/snapshot_packetizer.sv
// Frames an ADC snapshot sample stream into host frames: H0, payload, length word, integrity word.
// Optional build macro SNAP_PKT_CRC_EN swaps the additive checksum for CRC-16/CCITT.
module snapshot_packetizer #(
  parameter int PAYLOAD_LEN = 256,
  parameter int CNT_W       = 14
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        flush,
  output logic [15:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        fmt_err,
  output logic [13:0] frame_seq,
  output logic [2:0]  dbg_state
);

  // Handshake: a word transfers on a sys_clk edge where valid && ready; a held
  // word (valid && !ready) keeps data, valid and last unchanged.
  typedef enum logic [2:0] {IDLE, HDR, PAY, LEN, CHK} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_LEN);

`ifdef SNAP_PKT_CRC_EN
  localparam logic [15:0] INTEG_INIT = 16'hFFFF;

  // CRC-16/CCITT, poly 0x1021, MSB first; one full word per call.
  function automatic logic [15:0] integ_fold(input logic [15:0] acc, input logic [15:0] d);
    logic [15:0] c;
    c = acc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
`else
  localparam logic [15:0] INTEG_INIT = 16'h0000;

  function automatic logic [15:0] integ_fold(input logic [15:0] acc, input logic [15:0] d);
    return acc + d;
  endfunction
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [15:0]        integ_q, integ_d;
  logic               flush_pend_q, flush_pend_d;
  logic [13:0]        seq_q, seq_d;
  logic               fmt_err_q, fmt_err_d;
  logic [15:0]        m_data_q, m_data_d;
  logic               m_valid_q, m_valid_d;
  logic               m_last_q, m_last_d;
  logic               slot_free;
  logic [13:0]        len_field;

  assign slot_free = !m_valid_q || m_ready;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign len_field = 14'(cnt_q);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      integ_q      <= INTEG_INIT;
      flush_pend_q <= 1'b0;
      seq_q        <= '0;
      fmt_err_q    <= 1'b0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      integ_q      <= integ_d;
      flush_pend_q <= flush_pend_d;
      seq_q        <= seq_d;
      fmt_err_q    <= fmt_err_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    integ_d      = integ_q;
    flush_pend_d = flush_pend_q;
    seq_d        = seq_q;
    fmt_err_d    = fmt_err_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    m_valid_d    = m_valid_q;
    s_ready      = 1'b0;
    // A free slot empties unless a new word is loaded below.
    if (slot_free) m_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_valid) state_d = HDR;
      end
      HDR: begin
        if (flush) flush_pend_d = 1'b1;
        if (slot_free) begin
          m_valid_d = 1'b1;
          m_data_d  = {2'b10, seq_q};
          m_last_d  = 1'b0;
          state_d   = PAY;
        end
      end
      PAY: begin
        s_ready = slot_free;
        if (flush) flush_pend_d = 1'b1;
        if (s_valid && slot_free) begin
          m_valid_d = 1'b1;
          m_data_d  = s_data;
          m_last_d  = 1'b0;
          cnt_d     = cnt_inc;
          integ_d   = integ_fold(integ_q, s_data);
          if (s_data[15:14] != 2'b00) fmt_err_d = 1'b1;
          if (cnt_inc == LAST_CNT) state_d = LEN;
        end else if (flush_pend_q) begin
          state_d = LEN;
        end
      end
      LEN: begin
        if (slot_free) begin
          m_valid_d = 1'b1;
          m_data_d  = {2'b11, len_field};
          m_last_d  = 1'b0;
          state_d   = CHK;
        end
      end
      CHK: begin
        if (slot_free) begin
          m_valid_d    = 1'b1;
          m_data_d     = integ_q;
          m_last_d     = 1'b1;
          seq_d        = seq_q + 14'd1;
          cnt_d        = '0;
          integ_d      = INTEG_INIT;
          flush_pend_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign fmt_err   = fmt_err_q;
  assign frame_seq = seq_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_snapshot_packetizer.sv
// Scoreboard bench for snapshot_packetizer: a frame-level model queues expected words,
// a negedge monitor pops and compares each transferred output word.
module tb_snapshot_packetizer;
  localparam int PLEN = 4;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic [15:0] s_data  = 16'h0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        flush   = 1'b0;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;
  logic        fmt_err;
  logic [13:0] frame_seq;
  logic [2:0]  dbg_state;

  snapshot_packetizer #(.PAYLOAD_LEN(PLEN), .CNT_W(14)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .flush(flush), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .fmt_err(fmt_err),
    .frame_seq(frame_seq), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [16:0] exp_q[$];
  logic [15:0] smp_q[$];
  logic [13:0] model_seq = 14'd0;
  bit          rand_rdy = 1'b0;
  bit          mon_en   = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Integrity of the whole payload, treated as one long bit string.
  function automatic logic [15:0] model_integ();
`ifdef SNAP_PKT_CRC_EN
    logic [15:0] crc;
    logic        fb;
    crc = 16'hFFFF;
    foreach (smp_q[w]) begin
      for (int b = 15; b >= 0; b--) begin
        fb  = crc[15] ^ smp_q[w][b];
        crc = {crc[14:0], 1'b0};
        if (fb) crc = crc ^ 16'h1021;
      end
    end
    return crc;
`else
    int sum;
    sum = 0;
    foreach (smp_q[w]) sum += int'(smp_q[w]);
    return 16'(sum);
`endif
  endfunction

  task automatic model_frame();
    exp_q.push_back({1'b0, 2'b10, model_seq});
    foreach (smp_q[i]) exp_q.push_back({1'b0, smp_q[i]});
    exp_q.push_back({1'b0, 2'b11, 14'(smp_q.size())});
    exp_q.push_back({1'b1, model_integ()});
    model_seq = model_seq + 14'd1;
  endtask

  // ---------------- drivers ----------------
  always @(posedge sys_clk) begin
    #1;
    m_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  task automatic drive_sample(input logic [15:0] d, input bit fl);
    bit ok;
    ok      = 1'b0;
    s_data  = d;
    s_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge sys_clk);
      if (s_ready) begin
        ok = 1'b1;
        if (fl) flush = 1'b1;
        @(posedge sys_clk);
        #1;
        flush = 1'b0;
      end
    end
    check("sample_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain();
    s_valid = 1'b0;
    for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(negedge sys_clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge sys_clk);
    #1;
  endtask

  // fl_after: close a short frame with a flush pulse; fl_last: flush with final sample.
  task automatic send_frame(input bit fl_after, input bit fl_last);
    model_frame();
    foreach (smp_q[i]) drive_sample(smp_q[i], fl_last && (i == smp_q.size() - 1));
    if (fl_after) begin
      s_valid = 1'b0;
      flush   = 1'b1;
      @(posedge sys_clk);
      #1;
      flush = 1'b0;
      wait_drain();
    end
  endtask

  task automatic fill_random(input int n);
    smp_q.delete();
    for (int i = 0; i < n; i++) smp_q.push_back(16'($urandom_range(0, 16'h3FFF)));
  endtask

  // ---------------- monitor ----------------
  logic [16:0] held;
  bit          stalled = 1'b0;

  always @(negedge sys_clk) begin
    logic [16:0] e;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) check("stall_hold", {15'd0, m_valid, m_last, m_data}, {15'd0, 1'b1, held});
      if (m_valid && m_ready && mon_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h last=%0b expected none", m_data, m_last);
        end else begin
          e = exp_q.pop_front();
          check("out_word", {15'd0, m_last, m_data}, {15'd0, e});
        end
      end
      stalled = m_valid && !m_ready;
      held    = {m_last, m_data};
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    #23;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_fmt_err", 32'(fmt_err), 32'd0);
    check("rst_frame_seq", 32'(frame_seq), 32'd0);
    @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    // Directed frame 1..4 with header latency check.
    smp_q = '{16'd1, 16'd2, 16'd3, 16'd4};
    model_frame();
    s_data  = 16'd1;
    s_valid = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("h0_latency_1cyc", 32'(m_valid), 32'd0);
    @(negedge sys_clk);
    check("h0_latency_2cyc", 32'(m_valid), 32'd1);
    check("pay_s_ready", 32'(s_ready), 32'd1);
    @(posedge sys_clk);
    #1;
    for (int i = 1; i < 4; i++) drive_sample(smp_q[i], 1'b0);
    wait_drain();
    check("seq_after_first", 32'(frame_seq), 32'd1);
    check("fmt_err_clean", 32'(fmt_err), 32'd0);

    // Short frame closed by flush.
    smp_q = '{16'd5, 16'd6};
    send_frame(1'b1, 1'b0);
    check("seq_after_flush", 32'(frame_seq), 32'd2);

    // Ramp over three back-to-back frames with random backpressure.
    rand_rdy = 1'b1;
    for (int f = 0; f < 3; f++) begin
      smp_q.delete();
      for (int i = 0; i < PLEN; i++) smp_q.push_back(16'(16'h0100 + f * PLEN + i));
      send_frame(1'b0, 1'b0);
    end
    wait_drain();

    // Flush coinciding with the completing sample is absorbed.
    fill_random(PLEN);
    send_frame(1'b0, 1'b1);
    fill_random(PLEN);
    send_frame(1'b0, 1'b0);
    wait_drain();

    // Format error is forwarded and sticky.
    smp_q = '{16'd7, 16'h4001, 16'd8, 16'd9};
    send_frame(1'b0, 1'b0);
    wait_drain();
    check("fmt_err_set", 32'(fmt_err), 32'd1);
    for (int f = 0; f < 6; f++) begin
      int n;
      n = $urandom_range(1, PLEN);
      fill_random(n);
      send_frame(n < PLEN, 1'b0);
    end
    wait_drain();
    check("fmt_err_sticky", 32'(fmt_err), 32'd1);

    // Sequence wrap.
    rand_rdy = 1'b0;
    force dut.seq_q = 14'h3FFF;
    @(posedge sys_clk);
    #1;
    release dut.seq_q;
    model_seq = 14'h3FFF;
    @(posedge sys_clk);
    #1;
    check("seq_forced", 32'(frame_seq), 32'h3FFF);
    fill_random(PLEN);
    send_frame(1'b0, 1'b0);
    fill_random(PLEN);
    send_frame(1'b0, 1'b0);
    wait_drain();
    check("seq_after_wrap", 32'(frame_seq), 32'd1);

    // Reset in the middle of a payload.
    mon_en = 1'b0;
    drive_sample(16'h0011, 1'b0);
    drive_sample(16'h0022, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_m_data", 32'(m_data), 32'd0);
    check("midrst_m_last", 32'(m_last), 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    check("midrst_fmt_err", 32'(fmt_err), 32'd0);
    check("midrst_frame_seq", 32'(frame_seq), 32'd0);
    s_valid = 1'b0;
    exp_q.delete();
    model_seq = 14'd0;
    @(posedge sys_clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      check("post_rst_quiet", 32'(m_valid), 32'd0);
    end
    @(posedge sys_clk);
    #1;
    fill_random(PLEN);
    send_frame(1'b0, 1'b0);
    wait_drain();
    check("seq_after_midrst", 32'(frame_seq), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
